// File: rtl/booth_pkg.sv
// booth_pkg: shared states and widths for the shared Booth multiplier arbiter
package booth_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WAIT, RESP} state_e;
  localparam int OPW = 8;
  localparam int PRW = 16;
  localparam int DEF_TIMEOUT = 64;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin select, searching upward from ptr_i modulo N
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [N-1:0] rot;
  // rotate so ptr_i lands at bit 0, then the lowest set bit is the winner
  always_comb begin
    rot = N'({req_i, req_i} >> ptr_i);
    idx_o = '0;
    any_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        idx_o = IW'((int'(ptr_i) + k) % N);
        any_o = 1'b1;
      end
    end
    gnt_o = any_o ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin sharing of one byte-serial Booth multiplier with a watchdog
module booth_mul_arbiter
  import booth_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [OPW*NREQ-1:0] req_a,
  input  logic [OPW*NREQ-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [PRW-1:0]      rsp_data,
  output logic [IDW-1:0]      rsp_id,
  output logic                rsp_err,
  output logic                mul_start,
  output logic [OPW-1:0]      mul_data,
  input  logic                mul_done,
  input  logic [PRW-1:0]      mul_result,
  output logic                busy
);
  localparam int WW = $clog2(TIMEOUT);
  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d, id_q, id_d, pick_idx;
  logic [NREQ-1:0] pick_gnt;
  logic            pick_any;
  logic [OPW-1:0]  a_q, a_d, b_q, b_d;
  logic [PRW-1:0]  res_q, res_d;
  logic            err_q, err_d;
  logic [WW-1:0]   wd_q, wd_d;

  rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
    .req_i (req_valid),
    .ptr_i (rr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign req_ready = (state_q == IDLE) ? pick_gnt : '0;
  assign mul_start = state_q == LOAD_A;
  assign mul_data  = (state_q == LOAD_A) ? a_q : (state_q == LOAD_B) ? b_q : '0;
  assign rsp_valid = state_q == RESP;
  assign rsp_data  = res_q;
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;
  assign busy      = state_q != IDLE;

  // next-state: grant, operand sequencing, wait with watchdog, hold response
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          a_d     = req_a[int'(pick_idx)*OPW +: OPW];
          b_d     = req_b[int'(pick_idx)*OPW +: OPW];
          id_d    = pick_idx;
          rr_d    = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d = LOAD_A;
        end
      end
      LOAD_A: state_d = LOAD_B;
      LOAD_B: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_done) begin
          res_d   = mul_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // state and latches; reset aborts any transaction without a response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter: directed table-driven bench with a behavioural serial multiplier
module tb_booth_mul_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        mul_start, mul_done, busy;
  logic [7:0]  mul_data;
  logic [15:0] mul_result;
  logic        hang;
  int          tests = 0, fails = 0, cyc = 0;

  booth_mul_arbiter #(.NREQ(4), .IDW(2), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_data(mul_data), .mul_done(mul_done),
    .mul_result(mul_result), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural multiplier: A on start, B next cycle, done 10 cycles after B
  logic [7:0] a_m, b_m;
  logic       ph;
  int         cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph <= 1'b0; cnt <= 0; mul_done <= 1'b0; mul_result <= '0; a_m <= '0; b_m <= '0;
    end else begin
      ph <= mul_start;
      if (mul_start) a_m <= mul_data;
      if (ph) begin
        b_m <= mul_data;
        cnt <= 10;
      end else if (cnt != 0) cnt <= cnt - 1;
      mul_done <= (cnt == 1) && !hang;
      if (cnt == 1) mul_result <= 16'(16'($signed(a_m)) * 16'($signed(b_m)));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b);
    req_a[id*8 +: 8] = a;
    req_b[id*8 +: 8] = b;
    req_valid[id] = 1'b1;
  endtask

  task automatic txn(input int id, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp_d, input logic exp_e, input int exp_lat, input int hold);
    int n, g;
    logic stray, moved;
    #1;
    n = 0;
    while (req_ready == 0 && n < 100) begin @(negedge clk); #1; n++; end
    chk("grant", 32'(req_ready), 32'(4'b0001 << id));
    g = cyc;
    @(negedge clk); #1;
    req_valid[id] = 1'b0;
    chk("load_a_start", 32'(mul_start), 1);
    chk("load_a_data", 32'(mul_data), 32'(a));
    @(negedge clk); #1;
    chk("load_b_start", 32'(mul_start), 0);
    chk("load_b_data", 32'(mul_data), 32'(b));
    stray = 1'b0;
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk); #1; n++;
      stray |= (req_ready != 0);
    end
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("latency", 32'(cyc - g), 32'(exp_lat));
    chk("rsp_data", 32'(rsp_data), 32'(exp_d));
    chk("rsp_id", 32'(rsp_id), 32'(id));
    chk("rsp_err", 32'(rsp_err), 32'(exp_e));
    moved = 1'b0;
    repeat (hold) begin
      @(negedge clk); #1;
      stray |= (req_ready != 0);
      moved |= !rsp_valid || rsp_data !== exp_d || rsp_id !== 2'(id) || rsp_err !== exp_e;
    end
    chk("rsp_held", 32'(moved), 0);
    chk("no_stray_ready", 32'(stray), 0);
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    rsp_ready = 1'b0;
    chk("idle_after", 32'({busy, rsp_valid}), 0);
  endtask

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;
  vec_t tbl[4];

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen;
    tbl[0] = '{0, 8'h83, 8'h5A, 16'hD40E};
    tbl[1] = '{1, 8'h80, 8'h80, 16'h4000};
    tbl[2] = '{2, 8'h7F, 8'hFF, 16'hFF81};
    tbl[3] = '{3, 8'h00, 8'hB3, 16'h0000};
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0; hang = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, mul_start, mul_data, busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      set_req(tbl[i].id, tbl[i].a, tbl[i].b);
      txn(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].p, 1'b0, 14, 0);
    end
    set_req(1, 8'h03, 8'h04);
    set_req(3, 8'hFE, 8'h06);
    txn(1, 8'h03, 8'h04, 16'h000C, 1'b0, 14, 0);
    txn(3, 8'hFE, 8'h06, 16'hFFF4, 1'b0, 14, 0);
    set_req(1, 8'h10, 8'h10);
    set_req(0, 8'h02, 8'hFD);
    txn(0, 8'h02, 8'hFD, 16'hFFFA, 1'b0, 14, 0);
    txn(1, 8'h10, 8'h10, 16'h0100, 1'b0, 14, 0);
    set_req(2, 8'h09, 8'h09);
    set_req(3, 8'h01, 8'h01);
    txn(2, 8'h09, 8'h09, 16'h0051, 1'b0, 14, 20);
    txn(3, 8'h01, 8'h01, 16'h0001, 1'b0, 14, 0);
    hang = 1'b1;
    set_req(0, 8'h05, 8'h05);
    txn(0, 8'h05, 8'h05, 16'h0000, 1'b1, 67, 0);
    hang = 1'b0;
    set_req(1, 8'hF6, 8'h0A);
    txn(1, 8'hF6, 8'h0A, 16'hFF9C, 1'b0, 14, 0);
    set_req(0, 8'h03, 8'h03);
    #1;
    n = 0;
    while (req_ready == 0 && n < 100) begin @(negedge clk); #1; n++; end
    chk("rst_grant", 32'(req_ready), 32'h1);
    @(negedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("in_wait", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midwait_reset_outputs", {req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, mul_start, mul_data, busy}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin @(negedge clk); #1; seen |= rsp_valid | busy; end
    chk("no_aborted_rsp", 32'(seen), 0);
    set_req(2, 8'h05, 8'hF9);
    txn(2, 8'h05, 8'hF9, 16'hFFDD, 1'b0, 14, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
